mc_ctrl_fsm: RTL and testbench

Main control state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for R-type, lw, sw, beq, addi and j. It drives the 2-bit aluop consumed by the ALU-control decoder, plus all datapath mux and enable strobes. It stalls on a memory-ready handshake.

---
 rtl/mc_ctrl_pkg.sv | 152 +++++++++++++++
 rtl/mc_op_decode.sv | 50 +++++
 rtl/mc_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared definitions for the multi-cycle MIPS main control
//                FSM. It holds the state encodings, the opcode, aluop and mux
//                select constants, the opcode class enum, the control-word
//                struct, and the per-state control decode function.
//  Options     : none in this file (MC_CTRL_BNE_EN is used by the other files)
//  Revision    : 1.0  initial release
// ============================================================================
package mc_ctrl_pkg;

    // State encodings are visible on the debug port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_I_EXEC   = 4'd10,
        ST_I_WB     = 4'd11,
        ST_HOLD     = 4'd12
    } state_t;

    // instr[31:26] values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // aluop consumed by the ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Where DECODE sends each instruction
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_MEM     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_IMM     = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // Registered control word. 'fetch' marks the FETCH state so that the
    // PC/IR load strobes can be qualified by mem_ready at the top level.
    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
    } ctrl_t;

    // Moore decode of a state into its control word. HOLD and the unused
    // encodings fall through to all-zero.
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.aluop     = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Branch target precompute: PC + (imm << 2)
                c.alu_src_b = SRCB_IMM_SH;
                c.aluop     = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.aluop     = ALUOP_RTYPE;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_RT;
                c.aluop         = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            ST_I_WB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_op_decode
//  Description : Combinational opcode classifier for the main control FSM.
//                It maps instr[31:26] to the class DECODE dispatches on, and
//                flags unsupported opcodes.
//  Ports       : opcode   in  6  instr[31:26]
//                op_class out 3  dispatch class
//                is_store out 1  opcode is sw (selects MEM_WR over MEM_RD)
//                is_bne   out 1  opcode is bne (only with MC_CTRL_BNE_EN)
//                illegal  out 1  opcode not supported
//  Options     : MC_CTRL_BNE_EN - classify bne as a branch; when undefined
//                bne is illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic       is_store,
`ifdef MC_CTRL_BNE_EN
    output logic       is_bne,
`endif
    output logic       illegal
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE:     op_class = CLS_RTYPE;
            OP_LW, OP_SW: op_class = CLS_MEM;
            OP_BEQ:       op_class = CLS_BRANCH;
`ifdef MC_CTRL_BNE_EN
            OP_BNE:       op_class = CLS_BRANCH;
`endif
            OP_ADDI:      op_class = CLS_IMM;
            OP_J:         op_class = CLS_JUMP;
            default:      op_class = CLS_ILLEGAL;
        endcase
    end

    assign is_store = (opcode == OP_SW);
    assign illegal  = (op_class == CLS_ILLEGAL);
`ifdef MC_CTRL_BNE_EN
    assign is_bne   = (opcode == OP_BNE);
`endif

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Main control state machine of the multi-cycle MIPS
//                datapath. It sequences fetch / decode / execute / memory /
//                write-back for R-type, lw, sw, beq, addi and j, and stalls
//                on mem_ready in FETCH, MEM_RD and MEM_WR.
//  Parameters  : RESET_PC_HOLD - idle cycles in HOLD after reset release
//                before the first FETCH (0..15).
//  Ports       : clk, rst_n (async, active low)
//                opcode, zero, mem_ready               - inputs
//                pc_write, pc_write_cond, branch_ne,
//                iord, mem_read, mem_write, ir_write,
//                mem_to_reg, reg_dst, reg_write,
//                alu_src_a, alu_src_b, pc_source,
//                aluop                                 - datapath controls
//                state                                 - debug state
//                illegal_op                            - pulse in DECODE on
//                                                        unsupported opcode
//  Options     : MC_CTRL_BNE_EN - adds bne (opcode 000101) through BRANCH
//                with branch_ne=1. When undefined bne is illegal and
//                branch_ne is tied 0.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RESET_PC_HOLD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       illegal_op
);

    localparam logic [3:0] c_hold_limit = 4'(RESET_PC_HOLD);

    state_t    r_state;
    state_t    w_next;
    logic [3:0] r_hold_cnt;
    ctrl_t     r_ctrl;
    logic      r_is_store;

    op_class_t w_op_class;
    logic      w_is_store;
    logic      w_illegal;

    // The branch condition is resolved in the datapath (zero gated by
    // pc_write_cond); the controller does not need the flag itself.
    logic      w_unused_zero;
    assign w_unused_zero = zero;

`ifdef MC_CTRL_BNE_EN
    logic      w_is_bne;
    logic      r_branch_ne;
`endif

    mc_op_decode u_op_decode (
        .opcode   (opcode),
        .op_class (w_op_class),
        .is_store (w_is_store),
`ifdef MC_CTRL_BNE_EN
        .is_bne   (w_is_bne),
`endif
        .illegal  (w_illegal)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HOLD:     w_next = (r_hold_cnt == c_hold_limit) ? ST_FETCH : ST_HOLD;
            ST_FETCH:    w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_op_class)
                    CLS_RTYPE:  w_next = ST_R_EXEC;
                    CLS_MEM:    w_next = ST_MEM_ADDR;
                    CLS_BRANCH: w_next = ST_BRANCH;
                    CLS_IMM:    w_next = ST_I_EXEC;
                    CLS_JUMP:   w_next = ST_JUMP;
                    default:    w_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: w_next = r_is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   w_next = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WR:   w_next = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_R_EXEC:   w_next = ST_R_WB;
            ST_R_WB:     w_next = ST_FETCH;
            ST_BRANCH:   w_next = ST_FETCH;
            ST_JUMP:     w_next = ST_FETCH;
            ST_I_EXEC:   w_next = ST_I_WB;
            ST_I_WB:     w_next = ST_FETCH;
            default:     w_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. The control word is decoded from the
    // next state so the strobes line up with the state they belong to,
    // and the async reset clears them immediately.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_ctrl     <= '0;
            r_is_store <= 1'b0;
`ifdef MC_CTRL_BNE_EN
            r_branch_ne <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_decode(w_next);
            if ((r_state == ST_HOLD) && (w_next == ST_HOLD)) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
            // lw/sw choice is latched so MEM_ADDR does not depend on IR.
            if (r_state == ST_DECODE) begin
                r_is_store <= w_is_store;
            end
`ifdef MC_CTRL_BNE_EN
            // A bne in DECODE always goes to BRANCH next, so this is high
            // exactly for that BRANCH cycle.
            r_branch_ne <= (r_state == ST_DECODE) && w_is_bne;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Output assignment
    // ------------------------------------------------------------------
    assign pc_write      = r_ctrl.pc_write | (r_ctrl.fetch & mem_ready);
    assign ir_write      = r_ctrl.fetch & mem_ready;
    assign pc_write_cond = r_ctrl.pc_write_cond;
    assign iord          = r_ctrl.iord;
    assign mem_read      = r_ctrl.mem_read;
    assign mem_write     = r_ctrl.mem_write;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign reg_dst       = r_ctrl.reg_dst;
    assign reg_write     = r_ctrl.reg_write;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign pc_source     = r_ctrl.pc_source;
    assign aluop         = r_ctrl.aluop;
    assign state         = r_state;
    // Opcode is only valid from DECODE on, so the flag is qualified here.
    assign illegal_op    = (r_state == ST_DECODE) & w_illegal;

`ifdef MC_CTRL_BNE_EN
    assign branch_ne     = r_branch_ne;
`else
    assign branch_ne     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Self-checking bench for mc_ctrl_fsm. Builds the expected
//                state path of each instruction from its opcode class and
//                compares state and all control outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam int TB_HOLD = 2;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_BNE = 4,
                   K_ADDI = 5, K_J = 6, K_ILL = 7;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] aluop;
        logic       illegal_op;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source, aluop;
    logic [3:0] state;
    logic       illegal_op;
    outs_t      act;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.RESET_PC_HOLD(TB_HOLD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .aluop         (aluop),
        .state         (state),
        .illegal_op    (illegal_op)
    );

    assign act = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, pc_source, aluop, illegal_op};

    // ---------------- reference model ----------------
    function automatic int op_kind(input logic [5:0] op);
        case (op)
            T_RTYPE: return K_R;
            T_LW:    return K_LW;
            T_SW:    return K_SW;
            T_BEQ:   return K_BEQ;
`ifdef MC_CTRL_BNE_EN
            T_BNE:   return K_BNE;
`endif
            T_ADDI:  return K_ADDI;
            T_J:     return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Expected outputs while in state st (strobes always, selects where defined)
    function automatic outs_t exp_out(input int st, input logic mr, input logic bne,
                                      input logic ill);
        outs_t e;
        e = '0;
        case (st)
            0:  begin e.mem_read = 1; e.ir_write = mr; e.pc_write = mr; e.alu_src_b = 2'b01; end
            1:  begin e.alu_src_b = 2'b11; e.illegal_op = ill; end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_write = 1; e.iord = 1; end
            6:  begin e.alu_src_a = 1; e.aluop = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin e.alu_src_a = 1; e.aluop = 2'b11; e.pc_write_cond = 1;
                      e.pc_source = 2'b01; e.branch_ne = bne; end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: begin e.reg_write = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic outs_t exp_mask(input int st);
        outs_t m;
        m = '0;
        m.pc_write = 1; m.pc_write_cond = 1; m.branch_ne = 1; m.mem_read = 1;
        m.mem_write = 1; m.ir_write = 1; m.reg_write = 1; m.illegal_op = 1;
        case (st)
            0:  begin m.iord = 1; m.alu_src_a = 1; m.alu_src_b = '1; m.aluop = '1; m.pc_source = '1; end
            1, 2, 6, 10: begin m.alu_src_a = 1; m.alu_src_b = '1; m.aluop = '1; end
            3, 5: m.iord = 1;
            4, 7, 11: begin m.mem_to_reg = 1; m.reg_dst = 1; end
            8:  begin m.alu_src_a = 1; m.alu_src_b = '1; m.aluop = '1; m.pc_source = '1; end
            9:  m.pc_source = '1;
            default: m = '1;
        endcase
        return m;
    endfunction

    // Runs one instruction starting at a negedge with the FSM in FETCH.
    // rand_pct>0: mem_ready low with that probability every cycle;
    // otherwise mem_ready high except the first rd_wait MEM_RD cycles.
    task automatic run_instr(input logic [5:0] op, input int rand_pct,
                             input int rd_wait, output int rd_cycles);
        int path[$];
        int idx, guard, kind;
        logic mr, bne, ill;
        outs_t e, m;
        kind = op_kind(op);
        path = {0, 1};
        case (kind)
            K_R:    begin path.push_back(6); path.push_back(7); end
            K_LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
            K_SW:   begin path.push_back(2); path.push_back(5); end
            K_BEQ, K_BNE: path.push_back(8);
            K_ADDI: begin path.push_back(10); path.push_back(11); end
            K_J:    path.push_back(9);
            default: ;
        endcase
        bne = (kind == K_BNE);
        ill = (kind == K_ILL);
        idx = 0; guard = 0; rd_cycles = 0;
        while (idx < path.size() && guard < 200) begin
            int es;
            es = path[idx];
            if (rand_pct > 0)  mr = ($urandom_range(99) >= rand_pct);
            else if (es == 3)  mr = (rd_cycles >= rd_wait);
            else               mr = 1'b1;
            mem_ready = mr;
            opcode = (es == 0) ? 6'($urandom) : op;
            #1;
            vectors++;
            if (state !== 4'(es)) begin
                miscompares++;
                $display("FAIL state op=%b step=%0d: got %0d want %0d", op, idx, state, es);
            end
            e = exp_out(es, mr, bne, ill);
            m = exp_mask(es);
            vectors++;
            if (((act ^ e) & m) !== '0) begin
                miscompares++;
                $display("FAIL outputs op=%b state=%0d mr=%b: got %h want %h (mask %h)",
                         op, es, mr, act & m, e & m, m);
            end
            if (es == 3) rd_cycles++;
            @(posedge clk);
            if (!((es == 0 || es == 3 || es == 5) && !mr)) idx++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            miscompares++;
            $display("FAIL timeout op=%b: stuck at step %0d of %0d", op, idx, path.size());
        end
    endtask

    // Releases rst_n at a negedge and checks the HOLD window.
    task automatic release_and_hold();
        rst_n = 1'b1;
        for (int i = 0; i < TB_HOLD; i++) begin
            @(negedge clk);
            vectors++;
            if (state !== 4'd12 || act !== '0) begin
                miscompares++;
                $display("FAIL hold cycle %0d: got state %0d outs %h want 12 / 0", i, state, act);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int rc;
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (state !== 4'd12 || act !== '0) begin
            miscompares++;
            $display("FAIL reset: got state %0d outs %h want 12 / 0", state, act);
        end
        release_and_hold();
        run_instr(T_RTYPE, 0, 0, rc);   // first FETCH: ir_write=pc_write=1
    endtask

    task automatic test_rtype();
        int rc;
        run_instr(T_RTYPE, 0, 0, rc);
        run_instr(T_ADDI, 0, 0, rc);
        run_instr(T_J, 0, 0, rc);
        run_instr(T_SW, 0, 0, rc);
    endtask

    task automatic test_lw_wait();
        int rc;
        run_instr(T_LW, 0, 3, rc);
        vectors++;
        if (rc !== 4) begin
            miscompares++;
            $display("FAIL lw_wait MEM_RD cycles: got %0d want 4", rc);
        end
    endtask

    task automatic test_branch();
        int rc;
        run_instr(T_BEQ, 0, 0, rc);
        run_instr(T_BNE, 0, 0, rc);
        run_instr(T_BEQ, 0, 0, rc);
    endtask

    task automatic test_illegal();
        int rc;
        run_instr(6'b111111, 0, 0, rc);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_after: got state %0d illegal_op %b want 0 / 0", state, illegal_op);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        int rc;
        ops = '{T_RTYPE, T_LW, T_SW, T_BEQ, T_BNE, T_ADDI, T_J, 6'b000000};
        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(8);
            op = (sel == 8) ? 6'($urandom) : ops[sel];
            run_instr(op, 30, 0, rc);
        end
    endtask

    task automatic test_reset_mid_write();
        int rc;
        mem_ready = 1'b1; opcode = T_SW;
        repeat (3) @(posedge clk);          // FETCH -> DECODE -> MEM_ADDR -> MEM_WR
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL midwr_setup: got state %0d mem_write %b want 5 / 1", state, mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_write !== 1'b0 || state !== 4'd12 || act !== '0) begin
            miscompares++;
            $display("FAIL midwr_async: got mem_write %b state %0d outs %h want 0 / 12 / 0",
                     mem_write, state, act);
        end
        @(negedge clk);
        release_and_hold();
        run_instr(T_LW, 0, 1, rc);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_random();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
